// File: rtl/ysyx_220053_lsu.sv
// ysyx_220053_lsu: load/store responder between the EXU and a 64-bit data bus.
//   Captures one memory op per request. Handles lane alignment and byte masks,
//   then sign- or zero-extends the returned load data.
//   Optional: define YSYX_220053_LSU_MISALIGN_CHECK_EN to reject unaligned
//   accesses with resp_err and no bus traffic.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_*                 core request (valid/ready, wen, memop, addr, wdata)
//   resp_*                one-cycle completion pulse with load data / error
//   busy                  core stall
//   bus_*                 data-memory request channel and read-return channel
module ysyx_220053_lsu #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              wen_q, err_q;
  logic [2:0]        memop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q, rdata_q;
  logic [7:0]        wmask_q;

  // Request decode. memop[1:0]: 00 w, 01 b, 10 h, 11 d; memop[2] = unsigned.
  // A store with memop[2] set is illegal and degrades to a word store.
  logic       illegal_st, mis_abort, timeout_hit;
  logic [1:0] sz;
  logic [7:0] base_mask, req_wmask;
  logic [63:0] req_wdata_sh;

  assign illegal_st   = req_wen & req_memop[2];
  assign sz           = illegal_st ? 2'b00 : req_memop[1:0];
  assign req_wmask    = base_mask << req_addr[2:0];
  assign req_wdata_sh = req_wdata << {req_addr[2:0], 3'b000};

  always_comb begin
    base_mask = 8'h0F;
    case (sz)
      2'b01:   base_mask = 8'h01;
      2'b10:   base_mask = 8'h03;
      2'b11:   base_mask = 8'hFF;
      default: base_mask = 8'h0F;
    endcase
  end

`ifdef YSYX_220053_LSU_MISALIGN_CHECK_EN
  logic req_misalign;
  always_comb begin
    req_misalign = 1'b0;
    case (sz)
      2'b10:   req_misalign = req_addr[0];
      2'b00:   req_misalign = |req_addr[1:0];
      2'b11:   req_misalign = |req_addr[2:0];
      default: req_misalign = 1'b0;
    endcase
  end
  assign mis_abort = req_misalign;
`else
  assign mis_abort = 1'b0;
`endif

  // Counter starts at 0 on the first cycle of S_REQ/S_WAIT, so hitting
  // TIMEOUT-1 means TIMEOUT cycles have been spent there.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  logic capture, cap_rdata, to_abort;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cap_rdata = 1'b0;
    to_abort  = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        capture   = 1'b1;
        state_nxt = mis_abort ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (bus_ready) begin
          if (wen_q) state_nxt = S_RESP;
          else if (bus_rvalid) begin
            cap_rdata = 1'b1;
            state_nxt = S_RESP;
          end else state_nxt = S_WAIT;
        end else if (timeout_hit) begin
          to_abort  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          cap_rdata = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          to_abort  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      memop_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (state == S_REQ || state == S_WAIT) cnt <= cnt + 1'b1;
      else cnt <= '0;
      if (capture) begin
        wen_q   <= req_wen;
        memop_q <= req_memop;
        addr_q  <= req_addr;
        wdata_q <= req_wdata_sh;
        wmask_q <= req_wmask;
        err_q   <= illegal_st | mis_abort;
        rdata_q <= '0;
      end
      if (cap_rdata) rdata_q <= bus_rdata;
      if (to_abort)  err_q   <= 1'b1;
    end
  end

  // Load extraction from the captured bus word.
  logic [63:0] x, ext;
  assign x = rdata_q >> {addr_q[2:0], 3'b000};

  always_comb begin
    ext = x;
    case (memop_q[1:0])
      2'b01:   ext = memop_q[2] ? {56'd0, x[7:0]}  : {{56{x[7]}},  x[7:0]};
      2'b10:   ext = memop_q[2] ? {48'd0, x[15:0]} : {{48{x[15]}}, x[15:0]};
      2'b00:   ext = memop_q[2] ? {32'd0, x[31:0]} : {{32{x[31]}}, x[31:0]};
      default: ext = x;
    endcase
  end

  logic in_req, in_resp;
  assign in_req  = (state == S_REQ);
  assign in_resp = (state == S_RESP);

  assign req_ready  = (state == S_IDLE);
  assign busy       = req_valid | (state != S_IDLE);
  assign resp_valid = in_resp;
  assign resp_err   = in_resp & err_q;
  assign resp_rdata = (in_resp && !wen_q && !err_q) ? ext : 64'd0;

  assign bus_valid = in_req;
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus_wen   = in_req & wen_q;
  assign bus_wdata = in_req ? wdata_q : 64'd0;
  assign bus_wmask = in_req ? wmask_q : 8'd0;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
module tb_ysyx_220053_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_wen = 0, bus_ready = 0, bus_rvalid = 0;
  logic [2:0]  req_memop = 0;
  logic [63:0] req_addr = 0, req_wdata = 0, bus_rdata = 0;

  logic        req_ready, resp_valid, resp_err, busy, bus_valid, bus_wen;
  logic [63:0] resp_rdata, bus_addr, bus_wdata;
  logic [7:0]  bus_wmask;

  logic        t_req_ready, t_resp_valid, t_resp_err, t_busy, t_bus_valid, t_bus_wen;
  logic [63:0] t_resp_rdata, t_bus_addr, t_bus_wdata;
  logic [7:0]  t_bus_wmask;

  ysyx_220053_lsu u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  ysyx_220053_lsu #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_wen(req_wen), .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err), .busy(t_busy),
    .bus_valid(t_bus_valid), .bus_ready(bus_ready), .bus_addr(t_bus_addr), .bus_wen(t_bus_wen),
    .bus_wdata(t_bus_wdata), .bus_wmask(t_bus_wmask), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int n_run = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_memop = op; req_addr = addr; req_wdata = wdata;
    tick;
    req_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  op;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  wmask;
    logic [63:0] bwdata, rresp;
    logic        err;
  } vec_t;

  vec_t v[11];

  initial begin
    v[0]  = '{"lb",   0, 3'b001, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0};
    v[1]  = '{"lhu",  0, 3'b110, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 8'hC0, 64'h0, 64'h0000_0000_0000_8001, 0};
    v[2]  = '{"lh",   0, 3'b010, 64'h8000_0006, 64'h0, 64'h8001_0000_0000_0000, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0};
    v[3]  = '{"lw",   0, 3'b000, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321, 0};
    v[4]  = '{"lwu",  0, 3'b100, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 8'hF0, 64'h0, 64'h0000_0000_8765_4321, 0};
    v[5]  = '{"lbu",  0, 3'b101, 64'h8000_0007, 64'h0, 64'hFE00_0000_0000_0000, 8'h80, 64'h0, 64'h0000_0000_0000_00FE, 0};
    v[6]  = '{"ld",   0, 3'b011, 64'h8000_0000, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 0};
    v[7]  = '{"sb",   1, 3'b001, 64'h8000_0005, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 0};
    v[8]  = '{"sd",   1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0};
    v[9]  = '{"sill", 1, 3'b110, 64'h8000_0000, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'h0, 1};
    v[10] = '{"sw",   1, 3'b000, 64'h8000_0004, 64'hCAFE_BABE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0, 0};

    // Reset state.
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wmask", bus_wmask, 8'h00);
    chk("rst_rdata", resp_rdata, 64'h0);
    rst_n = 1'b1;
    tick;

    // Single-cycle-handshake table.
    foreach (v[i]) begin
      issue(v[i].wen, v[i].op, v[i].addr, v[i].wdata);
      chk({v[i].name, "_bus_valid"}, bus_valid, 1'b1);
      chk({v[i].name, "_bus_addr"}, bus_addr, v[i].addr & ~64'h7);
      chk({v[i].name, "_bus_wen"}, bus_wen, v[i].wen);
      chk({v[i].name, "_wmask"}, bus_wmask, v[i].wmask);
      if (v[i].wen) chk({v[i].name, "_wdata"}, bus_wdata, v[i].bwdata);
      bus_ready = 1'b1; bus_rvalid = !v[i].wen; bus_rdata = v[i].rdata;
      tick;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'h0;
      #1;
      chk({v[i].name, "_resp_valid"}, resp_valid, 1'b1);
      chk({v[i].name, "_resp_rdata"}, resp_rdata, v[i].rresp);
      chk({v[i].name, "_resp_err"}, resp_err, v[i].err);
      tick;
      chk({v[i].name, "_resp_drop"}, resp_valid, 1'b0);
      chk({v[i].name, "_ready_back"}, req_ready, 1'b1);
    end

    // sh with bus_ready held low for 3 cycles.
    issue(1'b1, 3'b010, 64'h8000_0006, 64'h1234);
    for (int k = 0; k < 3; k++) begin
      chk("sh_stall_valid", bus_valid, 1'b1);
      chk("sh_stall_wmask", bus_wmask, 8'hC0);
      chk("sh_stall_wdata", bus_wdata, 64'h1234_0000_0000_0000);
      chk("sh_stall_addr", bus_addr, 64'h8000_0000);
      chk("sh_stall_busy", busy, 1'b1);
      chk("sh_stall_resp", resp_valid, 1'b0);
      tick;
    end
    bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    #1;
    chk("sh_resp_valid", resp_valid, 1'b1);
    chk("sh_resp_err", resp_err, 1'b0);
    chk("sh_resp_rdata", resp_rdata, 64'h0);
    tick;
    chk("sh_resp_once", resp_valid, 1'b0);

    // ld accepted at once, data 5 cycles later through S_WAIT.
    issue(1'b0, 3'b011, 64'h8000_0010, 64'h0);
    bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("ld_wait_bus_valid", bus_valid, 1'b0);
      chk("ld_wait_resp", resp_valid, 1'b0);
      chk("ld_wait_busy", busy, 1'b1);
      if (k == 4) begin
        bus_rvalid = 1'b1; bus_rdata = 64'hFEDC_BA98_7654_3210;
      end
      tick;
    end
    bus_rvalid = 1'b0; bus_rdata = 64'h0;
    #1;
    chk("ld_wait_resp_valid", resp_valid, 1'b1);
    chk("ld_wait_rdata", resp_rdata, 64'hFEDC_BA98_7654_3210);
    tick;
    chk("ld_wait_resp_once", resp_valid, 1'b0);
    // Stray read returns while idle must not produce a response.
    bus_rvalid = 1'b1;
    tick;
    tick;
    bus_rvalid = 1'b0;
    chk("stray_rvalid_resp", resp_valid, 1'b0);
    chk("stray_rvalid_ready", req_ready, 1'b1);

    // Timeout (TIMEOUT=4 instance), bus_ready never asserted.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick;
    issue(1'b0, 3'b000, 64'h8000_0020, 64'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("to_bus_valid", t_bus_valid, 1'b1);
      chk("to_no_resp", t_resp_valid, 1'b0);
      tick;
    end
    chk("to_resp_valid", t_resp_valid, 1'b1);
    chk("to_resp_err", t_resp_err, 1'b1);
    chk("to_resp_rdata", t_resp_rdata, 64'h0);
    chk("to_bus_drop", t_bus_valid, 1'b0);
    tick;
    chk("to_resp_once", t_resp_valid, 1'b0);
    chk("to_ready_back", t_req_ready, 1'b1);

    // Reset pulse while in S_WAIT.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick;
    issue(1'b0, 3'b011, 64'h8000_0028, 64'h0);
    bus_ready = 1'b1;
    tick;
    bus_ready = 1'b0;
    #1;
    chk("rw_in_wait", bus_valid, 1'b0);
    chk("rw_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_ready", req_ready, 1'b1);
    chk("rw_busy0", busy, 1'b0);
    chk("rw_resp0", resp_valid, 1'b0);
    chk("rw_err0", resp_err, 1'b0);
    chk("rw_addr0", bus_addr, 64'h0);
    #2 rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 64'h5555_5555_5555_5555;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rw_no_resp", resp_valid, 1'b0);
    end
    bus_rvalid = 1'b0; bus_rdata = 64'h0;

    // Misaligned lw at offset 2.
    issue(1'b0, 3'b000, 64'h8000_0002, 64'h0);
`ifdef YSYX_220053_LSU_MISALIGN_CHECK_EN
    chk("mis_bus_valid", bus_valid, 1'b0);
    chk("mis_resp_valid", resp_valid, 1'b1);
    chk("mis_resp_err", resp_err, 1'b1);
    chk("mis_resp_rdata", resp_rdata, 64'h0);
    tick;
    chk("mis_resp_once", resp_valid, 1'b0);
`else
    chk("mis_bus_valid", bus_valid, 1'b1);
    chk("mis_wmask", bus_wmask, 8'h3C);
    bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'hAABB_CCDD_EEFF_0011;
    tick;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'h0;
    #1;
    chk("mis_resp_valid", resp_valid, 1'b1);
    chk("mis_resp_rdata", resp_rdata, 64'hFFFF_FFFF_CCDD_EEFF);
    chk("mis_resp_err", resp_err, 1'b0);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
